// File: rtl/jtframe_dump_pkg.sv
// Shared types for the dump window controller: channel states and trigger modes.
package jtframe_dump_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARMED = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_FRAME = 2'd1;
  localparam logic [1:0] MODE_DLOAD = 2'd2;
  localparam logic [1:0] MODE_NOW   = 2'd3;

endpackage

// File: rtl/jtframe_dump_chan.sv
// One dump channel: trigger state machine, window length counter and
// registered enable/start/stop/done strobes.
module jtframe_dump_chan
  import jtframe_dump_pkg::*;
#(
  parameter int FW = 32,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rearm,
  input  logic          vs_fall,
  input  logic          dl_fall,
  input  logic [FW-1:0] frame_cnt,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] start,
  input  logic [LW-1:0] len,
  output logic          dump_en,
  output logic          dump_start,
  output logic          dump_stop,
  output logic          done
);

  state_t        state, state_nxt;
  logic          init;
  logic          start_nxt, stop_nxt;
  logic [LW-1:0] len_cnt, len_cnt_nxt;
  logic          trig;

  // Reset parks the channel and arms it on the first cycle after release,
  // so the live mode decides between ARMED and OFF once rst is gone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OFF;
      init       <= 1'b1;
      dump_en    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      init       <= 1'b0;
      dump_en    <= (state_nxt == ST_DUMP);
      dump_start <= start_nxt;
      dump_stop  <= stop_nxt;
      done       <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    len_cnt <= len_cnt_nxt;
  end

  always_comb begin
    trig = 1'b0;
    case (mode)
      MODE_FRAME: trig = vs_fall && (frame_cnt == start);
      MODE_DLOAD: trig = dl_fall;
      MODE_NOW:   trig = 1'b1;
      default:    trig = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    len_cnt_nxt = len_cnt;
    start_nxt   = 1'b0;
    stop_nxt    = 1'b0;
    if (init || rearm) begin
      state_nxt = (mode == MODE_OFF) ? ST_OFF : ST_ARMED;
    end else begin
      case (state)
        ST_ARMED: begin
          if (trig) begin
            state_nxt   = ST_DUMP;
            len_cnt_nxt = '0;
            start_nxt   = 1'b1;
          end
        end
        ST_DUMP: begin
          // Switching the mode off aborts the window silently.
          if (mode == MODE_OFF) begin
            state_nxt = ST_OFF;
          end else if (vs_fall) begin
            if ((len != '0) && (len_cnt == len - LW'(1))) begin
              state_nxt = ST_DONE;
              stop_nxt  = 1'b1;
            end else begin
              len_cnt_nxt = len_cnt + LW'(1);
            end
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_dump_window.sv
// Dump window controller top: frame/download edge detection, frame counter,
// download holdoff and one trigger channel per probe group.
module jtframe_dump_window #(
  parameter int CH      = 4,
  parameter int FW      = 32,
  parameter int LW      = 16,
  parameter int HOLDOFF = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs,
  input  logic             dwnld,
  input  logic             rearm,
  input  logic [2*CH-1:0]  cfg_mode,
  input  logic [FW*CH-1:0] cfg_start,
  input  logic [LW*CH-1:0] cfg_len,
  output logic [FW-1:0]    frame_cnt,
  output logic [CH-1:0]    dump_en,
  output logic [CH-1:0]    dump_start,
  output logic [CH-1:0]    dump_stop,
  output logic [CH-1:0]    done
);

  localparam int HW = $clog2(HOLDOFF + 2);

  logic          vs_l, dwnld_l;
  logic          vs_fall, dl_fall, dl_qual;
  logic [HW-1:0] hold_cnt;

  assign vs_fall = vs_l & ~vs;
  assign dl_fall = dwnld_l & ~dwnld;
  // Download edges right after reset are start-up noise, not a real finish.
  assign dl_qual = dl_fall & (hold_cnt == HW'(HOLDOFF));

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_l      <= 1'b1;
      dwnld_l   <= 1'b0;
      hold_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      vs_l    <= vs;
      dwnld_l <= dwnld;
      if (hold_cnt != HW'(HOLDOFF)) hold_cnt <= hold_cnt + HW'(1);
      if (vs_fall) frame_cnt <= frame_cnt + FW'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    jtframe_dump_chan #(
      .FW(FW),
      .LW(LW)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .rearm      (rearm),
      .vs_fall    (vs_fall),
      .dl_fall    (dl_qual),
      .frame_cnt  (frame_cnt),
      .mode       (cfg_mode[2*i +: 2]),
      .start      (cfg_start[FW*i +: FW]),
      .len        (cfg_len[LW*i +: LW]),
      .dump_en    (dump_en[i]),
      .dump_start (dump_start[i]),
      .dump_stop  (dump_stop[i]),
      .done       (done[i])
    );
  end

endmodule

// File: tb/tb_jtframe_dump_window.sv
// Scoreboard bench for jtframe_dump_window: expected window events are queued
// per channel when stimulus is driven and checked cycle by cycle.
module tb_jtframe_dump_window;

  localparam int CH      = 4;
  localparam int FW      = 4;
  localparam int LW      = 16;
  localparam int HOLDOFF = 16;

  localparam int EV_START = 0;
  localparam int EV_STOP  = 1;
  localparam int EV_DROP  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             vs = 1'b1;
  logic             dwnld = 1'b0;
  logic             rearm = 1'b0;
  logic [2*CH-1:0]  cfg_mode = '0;
  logic [FW*CH-1:0] cfg_start = '0;
  logic [LW*CH-1:0] cfg_len = '0;
  logic [FW-1:0]    frame_cnt;
  logic [CH-1:0]    dump_en, dump_start, dump_stop, done;

  always #5 clk = ~clk;

  jtframe_dump_window #(
    .CH(CH), .FW(FW), .LW(LW), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vs         (vs),
    .dwnld      (dwnld),
    .rearm      (rearm),
    .cfg_mode   (cfg_mode),
    .cfg_start  (cfg_start),
    .cfg_len    (cfg_len),
    .frame_cnt  (frame_cnt),
    .dump_en    (dump_en),
    .dump_start (dump_start),
    .dump_stop  (dump_stop),
    .done       (done)
  );

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  ev_t           sb[CH][$];
  int            cyc = 0;
  int            ph = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  logic          mon_on = 1'b0;
  logic          clr_s = 1'b0;
  logic [CH-1:0] exp_en = '0;
  logic [CH-1:0] exp_done = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int ch, input int at, input int kind);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    sb[ch].push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vs is low for one cycle out of four: a frame edge every fourth cycle
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      vs = (ph % 4) != 3;
      ph++;
      tick();
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    clr_s <= rst | rearm;
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (clr_s) begin
        exp_en   = '0;
        exp_done = '0;
      end
      for (int i = 0; i < CH; i++) begin
        bit es, ep;
        es = 1'b0;
        ep = 1'b0;
        if (sb[i].size() > 0 && sb[i][0].cyc == cyc) begin
          case (sb[i][0].kind)
            EV_START: begin es = 1'b1; exp_en[i] = 1'b1; end
            EV_STOP:  begin ep = 1'b1; exp_en[i] = 1'b0; exp_done[i] = 1'b1; end
            default:  exp_en[i] = 1'b0;
          endcase
          void'(sb[i].pop_front());
        end
        chk($sformatf("dump_start[%0d]", i), dump_start[i], es);
        chk($sformatf("dump_stop[%0d]", i), dump_stop[i], ep);
        chk($sformatf("dump_en[%0d]", i), dump_en[i], exp_en[i]);
        chk($sformatf("done[%0d]", i), done[i], exp_done[i]);
      end
    end
  end

  int c0, r1, r2, c3;

  initial begin
    // ch0 off, ch1 frame 5 for 3 frames, ch2 after download for 2, ch3 now, unlimited
    cfg_mode  = {2'd3, 2'd2, 2'd1, 2'd0};
    cfg_start = {4'd0, 4'd0, 4'd5, 4'd0};
    cfg_len   = {16'd0, 16'd2, 16'd3, 16'd0};
    tick();
    mon_on = 1'b1;
    tick();
    tick();
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_dump_en", dump_en, 0);
    chk("rst_dump_start", dump_start, 0);
    chk("rst_dump_stop", dump_stop, 0);
    chk("rst_done", done, 0);

    rst = 1'b0;
    c0  = cyc;
    ph  = 0;
    expect_ev(3, c0 + 2, EV_START);
    expect_ev(1, c0 + 24, EV_START);
    expect_ev(1, c0 + 36, EV_STOP);
    expect_ev(2, c0 + 201, EV_START);
    expect_ev(2, c0 + 208, EV_STOP);
    dwnld = 1'b1;
    step(8);
    dwnld = 1'b0;
    step(1);
    dwnld = 1'b1;
    step(191);
    dwnld = 1'b0;
    step(220);
    chk("p1_frame_cnt", frame_cnt, 105 % 16);
    chk("p1_dump_en", dump_en, 4'b1000);
    chk("p1_done", done, 4'b0110);

    // rearm coinciding with a frame match must swallow the trigger
    cfg_start[4 +: 4] = 4'd10;
    cfg_len[16 +: 16] = 16'd1;
    r1 = cyc;
    rearm = 1'b1;
    expect_ev(3, r1 + 2, EV_START);
    step(1);
    rearm = 1'b0;
    step(6);
    r2 = cyc;
    rearm = 1'b1;
    expect_ev(3, r2 + 2, EV_START);
    step(1);
    rearm = 1'b0;
    cfg_start[4 +: 4] = 4'd12;
    expect_ev(1, r2 + 9, EV_START);
    expect_ev(1, r2 + 13, EV_STOP);
    step(16);
    chk("p2_frame_cnt", frame_cnt, 111 % 16);
    chk("p2_done1", done[1], 1);
    cfg_mode[6 +: 2] = 2'd0;
    expect_ev(3, cyc + 1, EV_DROP);
    step(4);
    chk("p2_off_en3", dump_en[3], 0);

    // frame counter wrap with a single frame-match channel
    cfg_mode  = {2'd0, 2'd0, 2'd1, 2'd0};
    cfg_start[4 +: 4] = 4'd2;
    cfg_len[16 +: 16] = 16'd0;
    rst = 1'b1;
    step(3);
    chk("p3_rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    ph = 0;
    c3 = cyc;
    expect_ev(1, c3 + 12, EV_START);
    step(80);
    chk("p3_frame_cnt", frame_cnt, 20 % 16);
    chk("p3_en1_open", dump_en[1], 1);
    rst = 1'b1;
    step(1);
    chk("p3_rst_en1", dump_en[1], 0);
    rst = 1'b0;
    step(10);

    for (int i = 0; i < CH; i++) chk($sformatf("pending[%0d]", i), sb[i].size(), 0);
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
